// File: rtl/pkg_UART.sv
// pkg_UART: shared UART control-register bit positions and RX handoff FSM states.
package pkg_UART;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SET  = 2'd2,
        ST_WAIT = 2'd3
    } rx_state_t;

    localparam int CTRL_SEND_BIT   = 0;
    localparam int CTRL_NEW_RX_BIT = 1;
    localparam int CTRL_OVR_BIT    = 2;

endpackage

// File: rtl/module_rx_fifo.sv
// module_rx_fifo: small byte FIFO with combinational head; push at full is accepted only alongside a pop.
module module_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din_i;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/module_fsm_rx.sv
// module_fsm_rx: buffers received bytes and hands them one at a time to the register file,
// waiting for software to clear the new-data bit between handoffs.
module module_fsm_rx
    import pkg_UART::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_done_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic [31:0]       control_rx_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              wr_data_o,
    output logic              set_new_o,
    output logic              ovr_o,
    output logic [CW-1:0]     count_o
);
    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] head;
    logic              fifo_full, fifo_empty, pop, new_rx;
    logic              unused_ctrl;

    assign new_rx      = control_rx_i[CTRL_NEW_RX_BIT];
    assign unused_ctrl = ^{control_rx_i[31:2], control_rx_i[0]};

    module_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rx_done_i),
        .pop_i   (pop),
        .din_i   (rx_data_i),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign pop       = state_q == ST_LOAD;
    assign wr_data_o = state_q == ST_LOAD;
    assign set_new_o = state_q == ST_SET;
    assign rx_data_o = rx_data_q;
    // A pop in ST_LOAD frees a slot in the same cycle, so only an idle full FIFO drops bytes
    assign ovr_o     = rx_done_i & fifo_full & ~pop;

    always_comb begin
        state_d   = state_q;
        rx_data_d = rx_data_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty && !new_rx) begin
                rx_data_d = head;
                state_d   = ST_LOAD;
            end
            ST_LOAD: state_d = ST_SET;
            ST_SET:  state_d = ST_WAIT;
            ST_WAIT: state_d = new_rx ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rx_data_q <= rx_data_d;
        end
    end

endmodule
